tlul_cmd_host: RTL and testbench

- Single-outstanding TL-UL host that turns a simple command stream (read/write, address, data, mask) into TL-UL A-channel requests and returns D-channel responses.
- Drives tl_i of the rv_timer register interface, and of any TL-UL device, from fuzz/stimulus harnesses.
- Turns flat fuzzer-generated command bytes into legal, protocol-correct bus traffic.

---
 rtl/tlul_pkg.sv | 44 ++++
 rtl/tlul_cmd_host.sv | 165 ++++++++++++++++
 tb/tb_tlul_cmd_host.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - minimal TL-UL channel types and opcodes shared by host and bench
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
        logic [3:0] instr_type;
    } tl_a_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '{cmd_intg: 7'h0, data_intg: 7'h0, instr_type: 4'h9};

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_host.sv
// rtl/tlul_cmd_host.sv - single-outstanding TL-UL host turning a flat command stream into bus traffic
// Optional WAIT-state response timeout and idle drain: define TLUL_CMD_HOST_TIMEOUT_EN.
module tlul_cmd_host #(
    parameter logic [7:0]  SourceId      = 8'h00,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [31:0]       cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_mask_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i
);
    import tlul_pkg::*;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

    state_e      state_q, state_d;
    logic        cmd_write_q, cmd_write_d;
    logic [29:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [3:0]  cmd_mask_q, cmd_mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef TLUL_CMD_HOST_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    assign rsp_timeout_o = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TimeoutCycles != 0);
    assign rsp_timeout_o  = 1'b0;
`endif

    logic unused_tl;
    assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user, cmd_addr_i[1:0]};

    assign busy_o      = (state_q != IDLE);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_mask_d  = cmd_mask_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
`endif
        tl_o        = '0;
        tl_o.a_user = TL_A_USER_DEFAULT;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
                // Drain any response that arrives after its transaction timed out.
                tl_o.d_ready = 1'b1;
`endif
                if (cmd_valid_i) begin
                    cmd_write_d = cmd_write_i;
                    cmd_addr_d  = cmd_addr_i[31:2];
                    cmd_wdata_d = cmd_wdata_i;
                    cmd_mask_d  = cmd_mask_i;
                    state_d     = REQ;
                end
            end
            REQ: begin
                tl_o.a_valid   = 1'b1;
                tl_o.a_size    = 2'd2;
                tl_o.a_source  = SourceId;
                tl_o.a_address = {cmd_addr_q, 2'b00};
                if (!cmd_write_q) begin
                    tl_o.a_opcode = Get;
                    tl_o.a_mask   = 4'hF;
                end else begin
                    tl_o.a_opcode = (cmd_mask_q == 4'hF) ? PutFullData : PutPartialData;
                    tl_o.a_mask   = cmd_mask_q;
                    tl_o.a_data   = cmd_wdata_q;
                end
                if (tl_i.a_ready) begin
                    state_d = WAIT;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                tl_o.d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    rdata_d = cmd_write_q ? 32'h0 : tl_i.d_data;
                    err_d   = tl_i.d_error | (tl_i.d_source != SourceId) |
                              (tl_i.d_opcode != (cmd_write_q ? AccessAck : AccessAckData));
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = RSP;
                end
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
                else if (cnt_q == CntMax) begin
                    rdata_d   = 32'h0;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_mask_q  <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_mask_q  <= cmd_mask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_tlul_cmd_host.sv
// tb/tb_tlul_cmd_host.sv - scoreboard bench for tlul_cmd_host with a behavioural device and reference model
module tb_tlul_cmd_host;

    localparam logic [7:0] SID = 8'h00;
    localparam int unsigned TMO = 4;
`ifdef TLUL_CMD_HOST_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0] cmd_mask = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    tlul_pkg::tl_h2d_t tl_o;
    tlul_pkg::tl_d2h_t tl_i = '0;

    always #5 clk = ~clk;

    tlul_cmd_host #(.SourceId(SID), .TimeoutCycles(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
        .tl_o(tl_o), .tl_i(tl_i)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } exp_a_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_r_t;

    exp_a_t exp_a_q[$];
    exp_r_t exp_r_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what a legal TL-UL host must put on the A channel for this command.
    function automatic exp_a_t model_a(input bit wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] mask);
        exp_a_t e;
        e.addr = addr - (addr % 4);
        if (!wr) begin
            e.op = 3'd4; e.mask = 4'hF; e.data = 32'h0;
        end else begin
            e.op = (mask == 4'hF) ? 3'd0 : 3'd1; e.mask = mask; e.data = wdata;
        end
        return e;
    endfunction

    function automatic exp_r_t model_r(input bit wr, input int d_delay, input bit d_err,
                                       input logic [7:0] d_src, input logic [2:0] d_op,
                                       input logic [31:0] d_data);
        exp_r_t r;
        if (d_delay < 0) begin
            r.rdata = 32'h0; r.err = 1'b1; r.tmo = 1'b1;
        end else begin
            r.rdata = wr ? 32'h0 : d_data;
            r.err   = d_err || (d_src != SID) || (d_op != (wr ? 3'd0 : 3'd1));
            r.tmo   = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && tl_o.a_valid) begin
            if (exp_a_q.size() == 0) chk("a_unexpected", 32'd1, 32'd0);
            else begin
                chk("a_opcode", 32'(tl_o.a_opcode), 32'(exp_a_q[0].op));
                chk("a_address", tl_o.a_address, exp_a_q[0].addr);
                chk("a_mask", 32'(tl_o.a_mask), 32'(exp_a_q[0].mask));
                chk("a_data", tl_o.a_data, exp_a_q[0].data);
                chk("a_size", 32'(tl_o.a_size), 32'd2);
                chk("a_source", 32'(tl_o.a_source), 32'(SID));
                chk("a_user", 32'(tl_o.a_user), 32'(tlul_pkg::TL_A_USER_DEFAULT));
                chk("req_d_ready", 32'(tl_o.d_ready), 32'd0);
                chk("req_cmd_ready", 32'(cmd_ready), 32'd0);
                if (tl_i.a_ready) void'(exp_a_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_r_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
                chk("rsp_rdata", rsp_rdata, exp_r_q[0].rdata);
                chk("rsp_err", 32'(rsp_err), 32'(exp_r_q[0].err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_r_q[0].tmo));
                chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("rsp_busy", 32'(busy), 32'd1);
                chk("rsp_d_ready", 32'(tl_o.d_ready), 32'd0);
                if (rsp_ready) void'(exp_r_q.pop_front());
            end
        end
        if (!rst && !busy) begin
            chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("idle_d_ready", 32'(tl_o.d_ready), 32'(TMO_EN));
        end
    end

    // d_delay < 0 means the device never answers (timeout build only).
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int a_stall, input int d_delay,
                           input bit d_err, input logic [7:0] d_src, input logic [2:0] d_op,
                           input logic [31:0] d_data, input int rsp_stall);
        exp_a_q.push_back(model_a(wr, addr, wdata, mask));
        exp_r_q.push_back(model_r(wr, d_delay, d_err, d_src, d_op, d_data));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        chk("a_valid_latency", 32'(tl_o.a_valid), 32'd1);
        repeat (a_stall) begin @(posedge clk); #1; end
        tl_i.a_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.a_ready = 1'b0;
        if (d_delay >= 0) begin
            repeat (d_delay) begin @(posedge clk); #1; end
            tl_i.d_valid = 1'b1; tl_i.d_error = d_err; tl_i.d_source = d_src;
            tl_i.d_opcode = d_op; tl_i.d_data = d_data;
            @(posedge clk); #1;
            tl_i = '0;
            chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        end else begin
            repeat (TMO - 1) begin @(posedge clk); #1; end
            chk("tmo_early", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
            chk("tmo_latency", 32'(rsp_valid), 32'd1);
        end
        repeat (rsp_stall) begin @(posedge clk); #1; end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("rst_d_ready", 32'(tl_o.d_ready), 32'(TMO_EN));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_a_user", 32'(tl_o.a_user), 32'(tlul_pkg::TL_A_USER_DEFAULT));
        chk("rst_a_opcode", 32'(tl_o.a_opcode), 32'd0);
        chk("rst_a_address", tl_o.a_address, 32'd0);
        chk("rst_a_mask", 32'(tl_o.a_mask), 32'd0);

        run_txn(1'b1, 32'h104, 32'h0000000F, 4'hF, 0, 1, 1'b0, SID, 3'd0, 32'h0, 0);
        run_txn(1'b0, 32'h10A, 32'h0, 4'h0, 0, 0, 1'b0, SID, 3'd1, 32'hDEADBEEF, 0);
        run_txn(1'b1, 32'h200, 32'h1234_5678, 4'h3, 0, 0, 1'b1, SID, 3'd0, 32'h0, 0);
        run_txn(1'b0, 32'h0FF, 32'h0, 4'h0, 3, 1, 1'b0, SID, 3'd1, 32'hA5A5_5A5A, 2);
        run_txn(1'b0, 32'h300, 32'h0, 4'h0, 0, 0, 1'b0, 8'h05, 3'd1, 32'h1111_2222, 0);
        run_txn(1'b1, 32'h303, 32'hCAFE_F00D, 4'h0, 1, 2, 1'b0, SID, 3'd0, 32'h0, 1);
        run_txn(1'b0, 32'h400, 32'h0, 4'h0, 0, 0, 1'b0, SID, 3'd0, 32'h7777_7777, 0);

        // Reset while the A request is still pending.
        exp_a_q.push_back(model_a(1'b0, 32'h500, 32'h0, 4'h0));
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h500;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_a_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_a_valid", 32'(tl_o.a_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);

`ifdef TLUL_CMD_HOST_TIMEOUT_EN
        run_txn(1'b0, 32'h600, 32'h0, 4'h0, 0, -1, 1'b0, SID, 3'd1, 32'h0, 1);
        tl_i.d_valid = 1'b1; tl_i.d_opcode = 3'd1; tl_i.d_data = 32'hBAD0_BAD0;
        #1 chk("late_d_ready", 32'(tl_o.d_ready), 32'd1);
        @(posedge clk); #1 tl_i = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk("late_no_rsp", 32'(rsp_valid), 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            bit wr;
            logic [3:0] m;
            logic [7:0] src;
            logic [2:0] op;
            wr  = $urandom_range(0, 1) == 1;
            m   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            src = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : SID;
            op  = wr ? 3'd0 : 3'd1;
            if ($urandom_range(0, 7) == 0) op = 3'($urandom_range(0, 2));
            run_txn(wr, $urandom, $urandom, m, $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 7) == 0, src, op, $urandom, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
        chk("r_queue_empty", 32'(exp_r_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
